// File: rtl/display_7seg_scan.sv
// Two-digit time-multiplexed 7-segment driver with per-slot anode blanking,
// optional leading-zero suppression and frame-coherent capture of Tens/Units.
module display_7seg_scan #(
   parameter int unsigned REFRESH_DIV    = 100000,
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned AN_ACTIVE_LOW  = 1,
   parameter int unsigned BLANK_LZ       = 1
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [3:0] Units,
   input  logic [3:0] Tens,
   output logic [6:0] Seg,
   output logic [1:0] AN,
   output logic       Frame_Tick
);

   localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [1:0]    AN_OFF     = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
   localparam logic [6:0]    SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   typedef enum logic [1:0] {StUBlank, StUOn, StTBlank, StTOn} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    units_q, units_d;
   logic [3:0]    tens_q, tens_d;
   logic [6:0]    seg_d;
   logic [1:0]    an_d;
   logic          tick_d;
   logic [1:0]    an_on;
   logic [6:0]    seg_hi;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      units_d = units_q;
      tens_d  = tens_q;
      tick_d  = 1'b0;
      unique case (state_q)
         StUBlank: if (cnt_q == BLANK_LAST) state_d = StUOn;
         StUOn: begin
            if (cnt_q == SLOT_LAST) begin
               state_d = StTBlank;
               cnt_d   = '0;
            end
         end
         StTBlank: if (cnt_q == BLANK_LAST) state_d = StTOn;
         StTOn: begin
            if (cnt_q == SLOT_LAST) begin
               state_d = StUBlank;
               cnt_d   = '0;
               units_d = Units;
               tens_d  = Tens;
               tick_d  = 1'b1;
            end
         end
         default: begin
            state_d = StUBlank;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are derived from the next state and next shadow so the
   // registered anode and segment values always change on the same edge.
   always_comb begin
      an_on  = 2'b00;
      seg_hi = 7'h00;
      unique case (state_d)
         StUOn: begin
            an_on  = 2'b01;
            seg_hi = decode(units_d);
         end
         StTOn: begin
            if (!((BLANK_LZ != 0) && (tens_d == 4'd0))) begin
               an_on  = 2'b10;
               seg_hi = decode(tens_d);
            end
         end
         default: begin
            an_on  = 2'b00;
            seg_hi = 7'h00;
         end
      endcase
      an_d  = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q    <= StUBlank;
         cnt_q      <= '0;
         units_q    <= 4'd0;
         tens_q     <= 4'd0;
         AN         <= AN_OFF;
         Seg        <= SEG_OFF;
         Frame_Tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         units_q    <= units_d;
         tens_q     <= tens_d;
         AN         <= an_d;
         Seg        <= seg_d;
         Frame_Tick <= tick_d;
      end
   end

endmodule

// File: tb/tb_display_7seg_scan.sv
// Directed bench for display_7seg_scan: one instance with leading-zero
// suppression, one without, sharing clock, reset and digit inputs.
module tb_display_7seg_scan;

   logic       CLK = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] Units = 4'd0;
   logic [3:0] Tens = 4'd0;
   logic [6:0] Seg, seg2;
   logic [1:0] AN, an2;
   logic       Frame_Tick, tick2;

   int pass_cnt = 0;
   int total_cnt = 0;
   int n;

   always #5 CLK = ~CLK;

   display_7seg_scan #(
      .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LZ(1)
   ) dut (
      .CLK(CLK), .Reset(Reset), .Units(Units), .Tens(Tens),
      .Seg(Seg), .AN(AN), .Frame_Tick(Frame_Tick)
   );

   display_7seg_scan #(
      .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LZ(0)
   ) dut_nolz (
      .CLK(CLK), .Reset(Reset), .Units(Units), .Tens(Tens),
      .Seg(seg2), .AN(an2), .Frame_Tick(tick2)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wait_tick(output int cycles);
      cycles = 0;
      do begin
         @(negedge CLK);
         cycles++;
      end while (!Frame_Tick && cycles < 40);
      chk("tick_seen", {7'd0, Frame_Tick}, 8'd1);
   endtask

   // Starts on the negedge where Frame_Tick is high (slot count 0 of U_BLANK).
   task automatic check_frame(input logic [6:0] us, input logic [1:0] tan1,
                              input logic [6:0] ts1, input logic [1:0] tan2,
                              input logic [6:0] ts2, input int chg_k,
                              input logic [3:0] chg_u);
      logic [1:0] ea1, ea2;
      logic [6:0] es1, es2;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge CLK);
         if (k < 2 || (k >= 8 && k < 10)) begin
            ea1 = 2'b11; es1 = 7'h7F; ea2 = 2'b11; es2 = 7'h7F;
         end else if (k < 8) begin
            ea1 = 2'b10; es1 = us; ea2 = 2'b10; es2 = us;
         end else begin
            ea1 = tan1; es1 = ts1; ea2 = tan2; es2 = ts2;
         end
         chk($sformatf("an k%0d", k), {6'd0, AN}, {6'd0, ea1});
         chk($sformatf("seg k%0d", k), {1'b0, Seg}, {1'b0, es1});
         chk($sformatf("tick k%0d", k), {7'd0, Frame_Tick}, {7'd0, (k == 0)});
         chk($sformatf("an_nolz k%0d", k), {6'd0, an2}, {6'd0, ea2});
         chk($sformatf("seg_nolz k%0d", k), {1'b0, seg2}, {1'b0, es2});
         chk($sformatf("tick_nolz k%0d", k), {7'd0, tick2}, {7'd0, (k == 0)});
         if (k == chg_k) Units = chg_u;
      end
   endtask

   // Called right after Reset is released on a negedge; ends on the first tick.
   task automatic after_release();
      for (int i = 1; i <= 16; i++) begin
         @(negedge CLK);
         chk($sformatf("rel_tick i%0d", i), {7'd0, Frame_Tick}, {7'd0, (i == 16)});
         if (i == 1) chk("rel_ublank_an", {6'd0, AN}, 8'h03);
         if (i == 2) begin
            chk("rel_uon_an", {6'd0, AN}, 8'h02);
            chk("rel_uon_seg_zero", {1'b0, Seg}, 8'h40);
            chk("rel_uon_seg_nolz", {1'b0, seg2}, 8'h40);
         end
      end
   endtask

   initial begin
      // Reset held
      Tens  = 4'd4;
      Units = 4'd7;
      repeat (4) begin
         @(negedge CLK);
         chk("rst_an", {6'd0, AN}, 8'h03);
         chk("rst_seg", {1'b0, Seg}, 8'h7F);
         chk("rst_tick", {7'd0, Frame_Tick}, 8'h00);
         chk("rst_an_nolz", {6'd0, an2}, 8'h03);
      end
      Reset = 1'b1;
      after_release();

      // 47 displayed
      check_frame(7'h78, 2'b01, 7'h19, 2'b01, 7'h19, -1, 4'd0);

      // 05: leading zero suppressed on one instance only
      Tens  = 4'd0;
      Units = 4'd5;
      wait_tick(n);
      chk("period_a", n[7:0], 8'd1);
      check_frame(7'h12, 2'b11, 7'h7F, 2'b01, 7'h40, -1, 4'd0);

      // Non-BCD inputs give dashes
      Tens  = 4'hF;
      Units = 4'hC;
      wait_tick(n);
      chk("period_b", n[7:0], 8'd1);
      check_frame(7'h3F, 2'b01, 7'h3F, 2'b01, 7'h3F, -1, 4'd0);

      // Units change mid-frame must not show until the next capture
      Tens  = 4'd4;
      Units = 4'd3;
      wait_tick(n);
      chk("period_c", n[7:0], 8'd1);
      check_frame(7'h30, 2'b01, 7'h19, 2'b01, 7'h19, 3, 4'd8);
      wait_tick(n);
      chk("period_d", n[7:0], 8'd1);
      check_frame(7'h00, 2'b01, 7'h19, 2'b01, 7'h19, -1, 4'd0);

      // Async reset during T_ON count 5
      wait_tick(n);
      chk("period_e", n[7:0], 8'd1);
      repeat (13) @(negedge CLK);
      chk("pre_rst_an", {6'd0, AN}, 8'h01);
      #1 Reset = 1'b0;
      #1;
      chk("async_rst_an", {6'd0, AN}, 8'h03);
      chk("async_rst_seg", {1'b0, Seg}, 8'h7F);
      chk("async_rst_tick", {7'd0, Frame_Tick}, 8'h00);
      chk("async_rst_an_nolz", {6'd0, an2}, 8'h03);
      @(negedge CLK);
      Reset = 1'b1;
      after_release();
      check_frame(7'h00, 2'b01, 7'h19, 2'b01, 7'h19, -1, 4'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
